// File: rtl/vga_timing_gen.sv
// VGA raster timing: divides clk by 4 into pixel ticks, walks h/v counters,
// and emits registered sync and colour aligned on the same pixel tick.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] pixel_in,
  output logic [9:0]  h_cnt,
  output logic [9:0]  v_cnt,
  output logic        pclk_en,
  output logic        valid,
  output logic        frame_start,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_LO   = H_VISIBLE + H_FRONT;
  localparam int HS_HI   = HS_LO + H_SYNC;
  localparam int VS_LO   = V_VISIBLE + V_FRONT;
  localparam int VS_HI   = VS_LO + V_SYNC;

  logic [1:0]  div;
  logic [11:0] rgb;
  logic        h_last;
  logic        v_last;
  logic        hs_raw;
  logic        vs_raw;

  assign pclk_en = (div == 2'd3);
  assign h_last  = (h_cnt == 10'(H_TOTAL - 1));
  assign v_last  = (v_cnt == 10'(V_TOTAL - 1));

  assign valid = (h_cnt < 10'(H_VISIBLE)) &&
                 (v_cnt < 10'(V_VISIBLE));

  assign frame_start = pclk_en && h_last && v_last;

  assign hs_raw = !((h_cnt >= 10'(HS_LO)) &&
                    (h_cnt <  10'(HS_HI)));
  assign vs_raw = !((v_cnt >= 10'(VS_LO)) &&
                    (v_cnt <  10'(VS_HI)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div   <= 2'd0;
      h_cnt <= 10'd0;
      v_cnt <= 10'd0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      rgb   <= 12'h000;
    end else begin
      div <= div + 2'd1;
      if (pclk_en) begin
        h_cnt <= h_last ? 10'd0 : h_cnt + 10'd1;
        if (h_last)
          v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
        // sync and colour share the tick so they stay aligned
        hsync <= hs_raw;
        vsync <= vs_raw;
        rgb   <= valid ? pixel_in : 12'h000;
      end
    end
  end

  assign vga_r = rgb[11:8];
  assign vga_g = rgb[7:4];
  assign vga_b = rgb[3:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster so whole frames fit
// in a short run; expectations come from elapsed-clock arithmetic.
module tb_vga_timing_gen;

  localparam int HV = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 2;
  localparam int VV = 5;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME_CLK = 4 * HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] pixel_in = 12'h000;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        pclk_en;
  logic        valid;
  logic        frame_start;
  logic        hsync;
  logic        vsync;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .pclk_en(pclk_en),
    .valid(valid), .frame_start(frame_start),
    .hsync(hsync), .vsync(vsync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // model: n = clk edges since reset release
  int          n = 0;
  logic [11:0] m_rgb = 12'h000;
  logic        m_hs = 1'b1;
  logic        m_vs = 1'b1;

  function automatic int pos_h(int t);
    return t % HT;
  endfunction

  function automatic int pos_v(int t);
    return (t / HT) % VT;
  endfunction

  function automatic bit e_pe();
    return (n % 4) == 3;
  endfunction

  function automatic int e_h();
    return pos_h(n / 4);
  endfunction

  function automatic int e_v();
    return pos_v(n / 4);
  endfunction

  function automatic bit e_valid();
    return e_h() < HV && e_v() < VV;
  endfunction

  function automatic bit e_fs();
    return e_pe() && e_h() == HT - 1 && e_v() == VT - 1;
  endfunction

  task automatic step(input logic [11:0] pix);
    int t;
    int ph;
    int pv;
    @(negedge clk);
    pixel_in = pix;
    @(posedge clk);
    if (n % 4 == 3) begin
      t  = n / 4;
      ph = pos_h(t);
      pv = pos_v(t);
      m_hs  = !(ph >= HV + HF && ph < HV + HF + HS);
      m_vs  = !(pv >= VV + VF && pv < VV + VF + VS);
      m_rgb = (ph < HV && pv < VV) ? pixel_in : 12'h000;
    end
    n++;
    #1;
  endtask

  task automatic restart();
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    n = 0;
    m_rgb = 12'h000;
    m_hs = 1'b1;
    m_vs = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (h_cnt !== 10'd0 || v_cnt !== 10'd0) begin
      errors++;
      $display("FAIL reset_cnt got h=%0d v=%0d exp 0/0", h_cnt, v_cnt);
    end
    vectors++;
    if (pclk_en !== 1'b0 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulse got pe=%b fs=%b exp 0/0", pclk_en, frame_start);
    end
    vectors++;
    if (hsync !== 1'b1 || vsync !== 1'b1) begin
      errors++;
      $display("FAIL reset_sync got hs=%b vs=%b exp 1/1", hsync, vsync);
    end
    vectors++;
    if ({vga_r, vga_g, vga_b} !== 12'h000) begin
      errors++;
      $display("FAIL reset_rgb got %h exp 000", {vga_r, vga_g, vga_b});
    end
    vectors++;
    if (valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_valid got %b exp 1", valid);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    n = 0;
  endtask

  task automatic test_divider();
    for (int i = 0; i < 64; i++) begin
      step(12'($urandom));
      vectors++;
      if (pclk_en !== e_pe()) begin
        errors++;
        $display("FAIL pclk_en n=%0d got %b exp %b", n, pclk_en, e_pe());
      end
      vectors++;
      if (h_cnt !== 10'(e_h())) begin
        errors++;
        $display("FAIL div_h n=%0d got %0d exp %0d", n, h_cnt, e_h());
      end
      if (n == 4) begin
        vectors++;
        if (h_cnt !== 10'd1) begin
          errors++;
          $display("FAIL first_tick got h=%0d exp 1", h_cnt);
        end
      end
    end
  endtask

  task automatic test_sync();
    int hs_low;
    int vs_low;
    hs_low = 0;
    vs_low = 0;
    restart();
    for (int i = 0; i < FRAME_CLK; i++) begin
      step(12'($urandom));
      if (hsync === 1'b0) hs_low++;
      if (vsync === 1'b0) vs_low++;
      vectors++;
      if (hsync !== m_hs || vsync !== m_vs) begin
        errors++;
        $display("FAIL sync n=%0d got %b%b exp %b%b",
                 n, hsync, vsync, m_hs, m_vs);
      end
    end
    vectors++;
    if (hs_low != 4 * HS * VT) begin
      errors++;
      $display("FAIL hs_width got %0d exp %0d", hs_low, 4 * HS * VT);
    end
    vectors++;
    if (vs_low != 4 * VS * HT) begin
      errors++;
      $display("FAIL vs_width got %0d exp %0d", vs_low, 4 * VS * HT);
    end
  endtask

  task automatic test_frame();
    int fs_cnt;
    fs_cnt = 0;
    restart();
    for (int i = 0; i < 2 * FRAME_CLK; i++) begin
      step(12'($urandom));
      if (frame_start === 1'b1) fs_cnt++;
      vectors++;
      if (h_cnt !== 10'(e_h()) || v_cnt !== 10'(e_v())) begin
        errors++;
        $display("FAIL cnt n=%0d got %0d/%0d exp %0d/%0d",
                 n, h_cnt, v_cnt, e_h(), e_v());
      end
      vectors++;
      if (valid !== e_valid() || frame_start !== e_fs()) begin
        errors++;
        $display("FAIL vld_fs n=%0d got %b%b exp %b%b",
                 n, valid, frame_start, e_valid(), e_fs());
      end
    end
    vectors++;
    if (fs_cnt != 2) begin
      errors++;
      $display("FAIL fs_count got %0d exp 2", fs_cnt);
    end
  endtask

  task automatic test_color_const();
    int seen;
    seen = 0;
    restart();
    for (int i = 0; i < FRAME_CLK; i++) begin
      step(12'hF0A);
      if ({vga_r, vga_g, vga_b} === 12'hF0A) seen++;
      vectors++;
      if ({vga_r, vga_g, vga_b} !== m_rgb) begin
        errors++;
        $display("FAIL rgb_const n=%0d got %h exp %h",
                 n, {vga_r, vga_g, vga_b}, m_rgb);
      end
    end
    vectors++;
    if (seen != 4 * HV * VV) begin
      errors++;
      $display("FAIL rgb_visible got %0d exp %0d", seen, 4 * HV * VV);
    end
  endtask

  task automatic test_glitch();
    restart();
    for (int i = 0; i < FRAME_CLK; i++) begin
      step(12'($urandom));
      vectors++;
      if ({vga_r, vga_g, vga_b} !== m_rgb) begin
        errors++;
        $display("FAIL rgb_glitch n=%0d got %h exp %h",
                 n, {vga_r, vga_g, vga_b}, m_rgb);
      end
    end
  endtask

  task automatic test_midframe_reset();
    int len;
    for (int k = 0; k < 4; k++) begin
      restart();
      len = int'($urandom_range(4 * HT + 1, FRAME_CLK - 2));
      for (int i = 0; i < len; i++) step(12'hFFF);
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (h_cnt !== 10'd0 || v_cnt !== 10'd0 ||
          pclk_en !== 1'b0 || frame_start !== 1'b0) begin
        errors++;
        $display("FAIL async_cnt got h=%0d v=%0d pe=%b fs=%b exp 0",
                 h_cnt, v_cnt, pclk_en, frame_start);
      end
      vectors++;
      if (hsync !== 1'b1 || vsync !== 1'b1 ||
          {vga_r, vga_g, vga_b} !== 12'h000) begin
        errors++;
        $display("FAIL async_out got hs=%b vs=%b rgb=%h exp 1 1 000",
                 hsync, vsync, {vga_r, vga_g, vga_b});
      end
      @(posedge clk);
      #2 rst_n = 1'b1;
      n = 0;
      m_rgb = 12'h000;
      m_hs = 1'b1;
      m_vs = 1'b1;
      for (int i = 0; i < 8; i++) begin
        step(12'($urandom));
        vectors++;
        if (pclk_en !== e_pe() || h_cnt !== 10'(e_h())) begin
          errors++;
          $display("FAIL restart n=%0d got pe=%b h=%0d exp %b %0d",
                   n, pclk_en, h_cnt, e_pe(), e_h());
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_divider();
    test_sync();
    test_frame();
    test_color_const();
    test_glitch();
    test_midframe_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
